turn_signal_ctrl: RTL and testbench
===================================

Name: turn_signal_ctrl

Overview:
- Front-end stage for the tail-light sequencers. Synchronizes and debounces the raw left, right, hazard and brake switches, and arbitrates them into a lighting mode.
- Drives the enable inputs of the left and right sequencer FSMs, plus the steady brake-lamp requests.
- Guarantees that every mode change drops the sequencer enables for a gap, so each downstream sequencer restarts from its idle pattern.
- Runs on the 1 kHz system clock.

Parameters:
- DEBOUNCE, 20, consecutive cycles a synchronized input must differ from its debounced value before that value updates (range 1..1023).
- GAP_CYCLES, 2, cycles both enables are held low when switching directly between two active modes (range 1..255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- left_sw  input  1  raw left-turn switch, asynchronous to clk.
- right_sw  input  1  raw right-turn switch, asynchronous to clk.
- hazard_sw  input  1  raw hazard switch, asynchronous to clk.
- brake_sw  input  1  raw brake switch, asynchronous to clk.
- left_ena  output  1  enable to the left sequencer.
- right_ena  output  1  enable to the right sequencer.
- left_steady  output  1  left lamps fully on (brake, side not sequencing).
- right_steady  output  1  right lamps fully on (brake, side not sequencing).
- mode  output  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous): the following are all cleared to 0.
  - sync flops, debounced values and debounce counters;
  - state=IDLE; gap counter;
  - every output.
  - Asserting reset mid-operation drops all outputs immediately.
  - The first clock edge after rst rises performs normal operation.
- Synchronizer, per input: two flops, s1 then s2.
- Debouncer, per input: 10-bit counter cnt and debounced value db.
  - If s2==db: cnt<=0.
  - Else if cnt==DEBOUNCE-1: db<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce (s2 returning to db) clears cnt. There is no partial credit.
- Latency: a raw change stable from before edge 0 updates db at edge DEBOUNCE+1. The FSM reacts at edge DEBOUNCE+2; at the defaults that is the 23rd edge.
- Request decode, from db values, combinational:
  - HAZ if hazard_db, or if left_db and right_db;
  - else LEFT if left_db;
  - else RIGHT if right_db;
  - else NONE.
- FSM states and encoding: IDLE=000, LEFT=001, RIGHT=010, HAZ=011, GAP=100. The mode output shows this encoding.
- IDLE: moves to the requested state (LEFT, RIGHT or HAZ) in one cycle; on NONE, stays.
- LEFT, RIGHT, HAZ:
  - request equals current state: stay;
  - request NONE: go to IDLE;
  - request is a different active mode: go to GAP and load the gap counter with GAP_CYCLES-1.
- GAP:
  - gap counter nonzero: decrement.
  - gap counter zero: go to the current request (IDLE if NONE).
  - Requests changing during GAP do not restart the gap.
  - GAP lasts exactly GAP_CYCLES cycles.
- Undefined state encodings: go to IDLE.
- Outputs: registered and decoded from the next state, so they change on the same edge as the state.
  - left_ena=1 in LEFT and HAZ; right_ena=1 in RIGHT and HAZ; both are 0 in IDLE and GAP.
  - left_steady = brake_db and not left_ena.
  - right_steady = brake_db and not right_ena.
  - In GAP with brake active, both steady outputs are 1.
- Simultaneous events:
  - left and right debounced on the same edge resolve to HAZ.
  - hazard and turn together resolve to HAZ.
  - Brake never affects the enables.

Test Plan:
- Reset, then left_sw=1 held steady -> left_ena stays 0 through edge 21 and rises at edge 22 (rising edges counted from 0); right_ena=0; mode=001.
- left_sw toggled every 5 cycles for 100 cycles, then settled at 0 -> left_ena never asserts; all debounce counters return to 0.
- In LEFT, set right_sw=1 with left_sw still 1 -> mode goes 001 to 100; both enables are 0 for exactly 2 cycles; then mode=011 with both enables 1.
- In RIGHT, assert brake_sw -> left_steady rises 22 edges after the change; right_steady stays 0; releasing right_sw (after debounce) gives mode=000 and right_steady=1.
- In HAZ, pull rst low between edges -> all outputs 0 before the next edge; after release with all switches 0, mode stays 000.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// Tail-light front end: synchronizes and debounces the four lamp switches,
// arbitrates them into a lighting mode and drives the sequencer enables.
module turn_signal_ctrl #(
    parameter int DEBOUNCE   = 20,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       brake_sw,
    output logic       left_ena,
    output logic       right_ena,
    output logic       left_steady,
    output logic       right_steady,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LEFT  = 3'b001,
        RIGHT = 3'b010,
        HAZ   = 3'b011,
        GAP   = 3'b100
    } state_t;

    localparam logic [9:0] DB_LAST  = 10'(DEBOUNCE - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    // bit order: 0 left, 1 right, 2 hazard, 3 brake
    logic [3:0] raw;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] db;
    logic [9:0] cnt [4];

    state_t     state;
    state_t     next_state;
    state_t     req;
    logic [7:0] gap_cnt;
    logic [7:0] gap_next;
    logic       left_ena_next;
    logic       right_ena_next;
    logic       left_steady_next;
    logic       right_steady_next;

    assign raw  = {brake_sw, hazard_sw, right_sw, left_sw};
    assign mode = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A bounce back to the debounced value throws away all accumulated count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 10'd1;
                end
            end
        end
    end

    always_comb begin
        req = IDLE;
        if (db[2] || (db[0] && db[1])) begin
            req = HAZ;
        end else if (db[0]) begin
            req = LEFT;
        end else if (db[1]) begin
            req = RIGHT;
        end
    end

    always_comb begin
        next_state = state;
        gap_next   = gap_cnt;
        case (state)
            IDLE: begin
                next_state = req;
            end
            LEFT, RIGHT, HAZ: begin
                if (req == IDLE) begin
                    next_state = IDLE;
                end else if (req != state) begin
                    next_state = GAP;
                    gap_next   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt != 8'd0) begin
                    gap_next = gap_cnt - 8'd1;
                end else begin
                    next_state = req;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        left_ena_next     = (next_state == LEFT) || (next_state == HAZ);
        right_ena_next    = (next_state == RIGHT) || (next_state == HAZ);
        left_steady_next  = db[3] && !left_ena_next;
        right_steady_next = db[3] && !right_ena_next;
    end

    // Outputs decode the next state so they switch on the same edge as mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            left_ena     <= 1'b0;
            right_ena    <= 1'b0;
            left_steady  <= 1'b0;
            right_steady <= 1'b0;
        end else begin
            state        <= next_state;
            gap_cnt      <= gap_next;
            left_ena     <= left_ena_next;
            right_ena    <= right_ena_next;
            left_steady  <= left_steady_next;
            right_steady <= right_steady_next;
        end
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl at default parameters; edges are counted
// from the first rising edge after an input change.
module tb_turn_signal_ctrl;

    logic       clk;
    logic       rst;
    logic       left_sw;
    logic       right_sw;
    logic       hazard_sw;
    logic       brake_sw;
    logic       left_ena;
    logic       right_ena;
    logic       left_steady;
    logic       right_steady;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;

    turn_signal_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .left_sw      (left_sw),
        .right_sw     (right_sw),
        .hazard_sw    (hazard_sw),
        .brake_sw     (brake_sw),
        .left_ena     (left_ena),
        .right_ena    (right_ena),
        .left_steady  (left_steady),
        .right_steady (right_steady),
        .mode         (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic le, input logic re,
                             input logic ls, input logic rs, input logic [2:0] md);
        check({tag, ".left_ena"}, 16'(left_ena), 16'(le));
        check({tag, ".right_ena"}, 16'(right_ena), 16'(re));
        check({tag, ".left_steady"}, 16'(left_steady), 16'(ls));
        check({tag, ".right_steady"}, 16'(right_steady), 16'(rs));
        check({tag, ".mode"}, 16'(mode), 16'(md));
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        left_sw   = 1'b0;
        right_sw  = 1'b0;
        hazard_sw = 1'b0;
        brake_sw  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state and left-turn latency: enable rises at edge 22
        do_reset();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        left_sw = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            step();
            check($sformatf("left_lat.e%0d.left_ena", i), 16'(left_ena), 16'(i == 22));
        end
        check_all("left_on", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);

        // Bouncing left switch never gets through the debouncer
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) left_sw = ~left_sw;
            step();
            check($sformatf("bounce.c%0d.left_ena", i), 16'(left_ena), 16'd0);
        end
        left_sw = 1'b0;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bounce.cnt%0d", i), 16'(dut.cnt[i]), 16'd0);
        end
        check("bounce.mode", 16'(mode), 16'd0);

        // LEFT -> GAP (2 cycles) -> HAZ when right joins
        do_reset();
        left_sw = 1'b1;
        for (int i = 0; i <= 22; i++) step();
        check("gap.pre.mode", 16'(mode), 16'd1);
        right_sw = 1'b1;
        for (int i = 0; i <= 21; i++) begin
            step();
            check($sformatf("gap.e%0d.mode", i), 16'(mode), 16'd1);
        end
        step();
        check_all("gap.e22", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        step();
        check_all("gap.e23", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        step();
        check_all("gap.e24", 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);

        // Left and right debounced on the same edge go straight to HAZ
        do_reset();
        left_sw  = 1'b1;
        right_sw = 1'b1;
        for (int i = 0; i <= 21; i++) step();
        check("both.e21.mode", 16'(mode), 16'd0);
        step();
        check_all("both.e22", 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);

        // Brake while in RIGHT, then release right
        do_reset();
        right_sw = 1'b1;
        for (int i = 0; i <= 22; i++) step();
        check_all("right_on", 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
        brake_sw = 1'b1;
        for (int i = 0; i <= 21; i++) step();
        check_all("brake.e21", 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
        step();
        check_all("brake.e22", 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        right_sw = 1'b0;
        for (int i = 0; i <= 21; i++) step();
        check_all("rel.e21", 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        step();
        check_all("rel.e22", 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);

        // Asynchronous reset in HAZ clears outputs before the next edge
        do_reset();
        hazard_sw = 1'b1;
        for (int i = 0; i <= 22; i++) step();
        check_all("haz_on", 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        hazard_sw = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            check($sformatf("post_rst.c%0d.mode", i), 16'(mode), 16'd0);
        end
        check_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
